// File: rtl/jt12_wr_bridge.sv
// jt12_wr_bridge: write-side front end of the FM core.
// Captures CPU register writes on the master clock, buffers them in a small
// FIFO and replays them into the divided internal domain, one per internal
// cycle. Also produces the internal clock enable, the synchronised internal
// reset and the CPU-visible status byte.
//
// Optional feature macro: JT12_WR_OVF_FLAG_EN
//   defined   -> sticky overflow flag on dropped writes, shown on cpu_dout[6]
//   undefined -> overflow and cpu_dout[6] tied to 0, drops stay silent
`timescale 1ns/1ps

module jt12_wr_bridge #(
  parameter int unsigned DIV      = 6,   // master clocks per internal cycle (2..63)
  parameter int unsigned DEPTH    = 4,   // FIFO entries, power of 2 (2..16)
  parameter int unsigned BUSY_CYC = 32   // internal cycles of busy after a data write (1..255)
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cpu_wr,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cen_int,
  output logic       rst_int,
  output logic       int_wr,
  output logic       int_part,
  output logic       int_a0,
  output logic [7:0] int_din,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [5:0]  PH_LAST   = 6'(DIV - 1);
  localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [7:0]  BUSY_LOAD = 8'(BUSY_CYC);

  // ---------------------------------------------------------------------------
  // Phase counter and internal clock enable
  // ---------------------------------------------------------------------------
  logic [5:0] ph_q, ph_d;
  logic       cen_q, cen_d;
  logic       ph_last_s;

  // Next phase: count 0..DIV-1 and wrap; enable goes high the cycle after the last phase.
  always_comb begin
    ph_last_s = (ph_q == PH_LAST);
    ph_d      = ph_q;
    cen_d     = 1'b0;
    if (ph_last_s) begin
      ph_d  = 6'd0;
      cen_d = 1'b1;
    end else begin
      ph_d  = ph_q + 6'd1;
      cen_d = 1'b0;
    end
  end

  // Phase counter and registered clock enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= 6'd0;
      cen_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      cen_q <= cen_d;
    end
  end

  assign cen_int = cen_q;

  // ---------------------------------------------------------------------------
  // Internal reset: two-stage shifter advanced together with the enable pulse,
  // so rst_int drops on the same edge as the second cen_int rise.
  // ---------------------------------------------------------------------------
  logic [1:0] rsync_q, rsync_d;
  logic       rst_int_s;

  // Shift a zero in once per internal cycle.
  always_comb begin
    rsync_d = rsync_q;
    if (ph_last_s) begin
      rsync_d = {rsync_q[0], 1'b0};
    end else begin
      rsync_d = rsync_q;
    end
  end

  // Reset synchroniser register, forced high by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsync_q <= 2'b11;
    end else begin
      rsync_q <= rsync_d;
    end
  end

  assign rst_int_s = rsync_q[1];
  assign rst_int   = rst_int_s;

  // ---------------------------------------------------------------------------
  // Write FIFO: entries are {part, a0, din}; pointers carry one extra bit so
  // that a full FIFO and an empty FIFO have different occupancy counts.
  // ---------------------------------------------------------------------------
  logic [9:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_s;
  logic        empty_s;
  logic        full_s;
  logic        wr_en_s;
  logic        push_s;
  logic        pop_s;
  logic [9:0]  head_s;
  logic [9:0]  entry_s;

  // Occupancy, push/pop decisions and pointer updates.
  always_comb begin
    count_s  = wr_ptr_q - rd_ptr_q;
    empty_s  = (count_s == CNT_ZERO);
    full_s   = (count_s == CNT_FULL);
    head_s   = mem_q[rd_ptr_q[AW-1:0]];
    entry_s  = {cpu_addr[1], cpu_addr[0], cpu_din};
    // Pop only on an enable edge while out of reset and with data present;
    // a write into an empty FIFO therefore waits for the next enable.
    pop_s    = cen_q & ~rst_int_s & ~empty_s;
    // Writes during internal reset are ignored entirely.
    wr_en_s  = cpu_wr & ~rst_int_s;
    // A full FIFO still accepts a write when a pop frees a slot on the same edge.
    push_s   = wr_en_s & (~full_s | pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO pointers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= CNT_ZERO;
      rd_ptr_q <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so no stale entry can ever be replayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 10'd0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Replay port: fields load on each pop, int_wr drops on an enable edge that
  // finds the FIFO empty; fields hold their last values.
  // ---------------------------------------------------------------------------
  logic       int_wr_q, int_wr_d;
  logic       int_part_q, int_part_d;
  logic       int_a0_q, int_a0_d;
  logic [7:0] int_din_q, int_din_d;

  // Next replay outputs, updated only on enable edges.
  always_comb begin
    int_wr_d   = int_wr_q;
    int_part_d = int_part_q;
    int_a0_d   = int_a0_q;
    int_din_d  = int_din_q;
    if (cen_q) begin
      if (pop_s) begin
        int_wr_d   = 1'b1;
        int_part_d = head_s[9];
        int_a0_d   = head_s[8];
        int_din_d  = head_s[7:0];
      end else begin
        int_wr_d   = 1'b0;
      end
    end else begin
      int_wr_d = int_wr_q;
    end
  end

  // Replay output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_wr_q   <= 1'b0;
      int_part_q <= 1'b0;
      int_a0_q   <= 1'b0;
      int_din_q  <= 8'd0;
    end else begin
      int_wr_q   <= int_wr_d;
      int_part_q <= int_part_d;
      int_a0_q   <= int_a0_d;
      int_din_q  <= int_din_d;
    end
  end

  assign int_wr   = int_wr_q;
  assign int_part = int_part_q;
  assign int_a0   = int_a0_q;
  assign int_din  = int_din_q;

  // ---------------------------------------------------------------------------
  // Busy status: a data pop (re)loads the counter, which then counts down one
  // per internal cycle. busy is sampled from the pre-edge state, so it trails
  // the causing push/pop by one clk.
  // ---------------------------------------------------------------------------
  logic [7:0] busy_cnt_q, busy_cnt_d;
  logic       busy_q, busy_d;

  // Busy counter reload/decrement and registered busy flag.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (pop_s && head_s[8]) begin
      busy_cnt_d = BUSY_LOAD;
    end else if (cen_q && (busy_cnt_q != 8'd0)) begin
      busy_cnt_d = busy_cnt_q - 8'd1;
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
    busy_d = ~empty_s | (busy_cnt_q != 8'd0);
  end

  // Busy counter and busy flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef JT12_WR_OVF_FLAG_EN
  logic drop_s;
  logic ovf_q, ovf_d;

  // A write that finds the FIFO full with no simultaneous pop sets the sticky flag.
  always_comb begin
    drop_s = wr_en_s & full_s & ~pop_s;
    ovf_d  = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky overflow register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign cpu_dout = {busy_q, overflow, 6'b00_0000};

endmodule

// File: tb/tb_jt12_wr_bridge.sv
// Self-checking bench for jt12_wr_bridge (DIV=6, DEPTH=4, BUSY_CYC=32).
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_jt12_wr_bridge;

  logic       rst;
  logic       clk;
  logic       cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cen_int;
  logic       rst_int;
  logic       int_wr;
  logic       int_part;
  logic       int_a0;
  logic [7:0] int_din;
  logic       busy;
  logic       overflow;

  int total = 0;
  int bad   = 0;

`ifdef JT12_WR_OVF_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  jt12_wr_bridge #(.DIV(6), .DEPTH(4), .BUSY_CYC(32)) dut (
    .rst      (rst),
    .clk      (clk),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cen_int  (cen_int),
    .rst_int  (rst_int),
    .int_wr   (int_wr),
    .int_part (int_part),
    .int_a0   (int_a0),
    .int_din  (int_din),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    logic       exp_part;
    logic       exp_a0;
    logic [7:0] exp_din;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cen();
    int n;
    n = 0;
    while (cen_int !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cen", {31'd0, cen_int}, 32'd1);
  endtask

  task automatic wait_intwr(output int n);
    n = 0;
    while (int_wr !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic write1(input logic [1:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    @(negedge clk);
    cpu_wr   = 1'b0;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int hi;
    int k_end;
    logic [7:0] got [5];

    vecs[0] = '{addr: 2'b10, din: 8'h28, exp_part: 1'b1, exp_a0: 1'b0, exp_din: 8'h28};
    vecs[1] = '{addr: 2'b00, din: 8'hB4, exp_part: 1'b0, exp_a0: 1'b0, exp_din: 8'hB4};
    vecs[2] = '{addr: 2'b10, din: 8'h5A, exp_part: 1'b1, exp_a0: 1'b0, exp_din: 8'h5A};
    vecs[3] = '{addr: 2'b00, din: 8'hC3, exp_part: 1'b0, exp_a0: 1'b0, exp_din: 8'hC3};

    rst      = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 2'b00;
    cpu_din  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_cen",      {31'd0, cen_int},  32'd0);
    chk("rst_rst_int",  {31'd0, rst_int},  32'd1);
    chk("rst_int_wr",   {31'd0, int_wr},   32'd0);
    chk("rst_int_din",  {24'd0, int_din},  32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_dout",     {24'd0, cpu_dout}, 32'd0);

    // Clock enable cadence and internal reset release.
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk($sformatf("cen_edge%0d", k), {31'd0, cen_int}, {31'd0, (k % 6) == 0});
      chk($sformatf("rst_int_edge%0d", k), {31'd0, rst_int}, {31'd0, k < 12});
    end
    chk("post_rst_int_wr", {31'd0, int_wr}, 32'd0);
    chk("post_rst_busy",   {31'd0, busy},   32'd0);

    // Single address writes from the table.
    for (int i = 0; i < 4; i++) begin
      wait_cen();
      write1(vecs[i].addr, vecs[i].din);
      chk($sformatf("v%0d_busy_lag", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_busy_queued", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_no_bypass", i), {31'd0, int_wr}, 32'd0);
      wait_intwr(n);
      chk($sformatf("v%0d_latency", i), n, 32'd5);
      chk($sformatf("v%0d_part", i), {31'd0, int_part}, {31'd0, vecs[i].exp_part});
      chk($sformatf("v%0d_a0", i),   {31'd0, int_a0},   {31'd0, vecs[i].exp_a0});
      chk($sformatf("v%0d_din", i),  {24'd0, int_din},  {24'd0, vecs[i].exp_din});
      chk($sformatf("v%0d_busy_pop", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_clear", i), {31'd0, busy}, 32'd0);
      hi = 1;
      while (int_wr === 1'b1 && hi < 20) begin
        hi++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_wr_len", i), hi, 32'd6);
      chk($sformatf("v%0d_din_hold", i), {24'd0, int_din}, {24'd0, vecs[i].exp_din});
    end

    // Data write: busy window of 32 internal cycles after the replay.
    wait_cen();
    write1(2'b01, 8'hF0);
    wait_intwr(n);
    chk("data_latency", n, 32'd6);
    chk("data_a0",  {31'd0, int_a0},  32'd1);
    chk("data_din", {24'd0, int_din}, 32'hF0);
    k_end = 0;
    while (k_end < 300) begin
      @(negedge clk);
      k_end++;
      if (k_end == 100) chk("data_dout_busy", {24'd0, cpu_dout}, 32'h80);
      if (busy !== 1'b1) break;
    end
    chk("data_busy_len", k_end, 32'd193);
    chk("data_dout_idle", {24'd0, cpu_dout}, 32'h00);

    // Burst of four writes on consecutive clocks.
    wait_cen();
    write1(2'b00, 8'h22);
    write1(2'b10, 8'h0F);
    write1(2'b00, 8'h2B);
    write1(2'b10, 8'h80);
    wait_intwr(n);
    chk("burst_latency", n, 32'd3);
    got[0] = 8'h22; got[1] = 8'h0F; got[2] = 8'h2B; got[3] = 8'h80;
    hi = 0;
    for (int j = 0; j < 24; j++) begin
      if (j % 6 == 0) begin
        chk($sformatf("burst_din%0d", j / 6),  {24'd0, int_din},  {24'd0, got[j / 6]});
        chk($sformatf("burst_part%0d", j / 6), {31'd0, int_part}, {31'd0, ((j / 6) % 2) == 1});
      end
      if (int_wr === 1'b1) hi++;
      @(negedge clk);
    end
    chk("burst_wr_len", hi, 32'd24);
    chk("burst_wr_end", {31'd0, int_wr}, 32'd0);

    // Overflow: five writes within one internal cycle, the fifth is dropped.
    wait_cen();
    for (int j = 1; j <= 5; j++) write1(2'b00, 8'(j));
    wait_intwr(n);
    hi = 0;
    for (int j = 0; j < 36; j++) begin
      if (j % 6 == 0 && j < 24) chk($sformatf("ovf_din%0d", j / 6), {24'd0, int_din}, (j / 6) + 1);
      if (int_wr === 1'b1) hi++;
      @(negedge clk);
    end
    chk("ovf_replayed", hi, 32'd24);
    chk("ovf_flag",     {31'd0, overflow},    {31'd0, OVF_EXP});
    chk("ovf_dout6",    {31'd0, cpu_dout[6]}, {31'd0, OVF_EXP});

    // Full FIFO accepts a write on the same edge as a pop.
    wait_cen();
    write1(2'b00, 8'h31);
    write1(2'b00, 8'h32);
    write1(2'b00, 8'h33);
    write1(2'b00, 8'h34);
    @(negedge clk);
    @(negedge clk);
    write1(2'b00, 8'h35);
    got[0] = 8'h31; got[1] = 8'h32; got[2] = 8'h33; got[3] = 8'h34; got[4] = 8'h35;
    hi = 0;
    for (int j = 0; j < 36; j++) begin
      if (j % 6 == 0 && j < 30) chk($sformatf("fullpop_din%0d", j / 6), {24'd0, int_din}, {24'd0, got[j / 6]});
      if (int_wr === 1'b1) hi++;
      @(negedge clk);
    end
    chk("fullpop_replayed", hi, 32'd30);
    chk("fullpop_ovf", {31'd0, overflow}, {31'd0, OVF_EXP});

    // Mid-operation reset with three queued entries and busy counter at 10.
    wait_cen();
    write1(2'b01, 8'h11);
    wait_intwr(n);
    chk("mid_latency", n, 32'd6);
    repeat (132) @(negedge clk);
    write1(2'b00, 8'h41);
    write1(2'b00, 8'h42);
    write1(2'b00, 8'h43);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_async_busy",    {31'd0, busy},    32'd0);
    chk("mid_async_rst_int", {31'd0, rst_int}, 32'd1);
    @(negedge clk);
    chk("mid_busy",     {31'd0, busy},     32'd0);
    chk("mid_int_wr",   {31'd0, int_wr},   32'd0);
    chk("mid_rst_int",  {31'd0, rst_int},  32'd1);
    chk("mid_int_din",  {24'd0, int_din},  32'd0);
    chk("mid_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_dout",     {24'd0, cpu_dout}, 32'd0);
    rst = 1'b0;
    n = 0;
    hi = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (int_wr === 1'b1) n++;
      if (busy === 1'b1) hi++;
    end
    chk("mid_no_stale_replay", n,  32'd0);
    chk("mid_no_stale_busy",   hi, 32'd0);
    chk("mid_rst_int_released", {31'd0, rst_int}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt12_wr_bridge.md
Name: jt12_wr_bridge

Overview:
- Write-side front end of the FM core.
- Accepts CPU register writes (address/data, two parts) on the master clock and buffers them in a small FIFO.
- Generates the divided internal clock enable and replays buffered writes into the internal domain, one per internal cycle.
- Produces the synchronised internal reset and the CPU-visible busy status byte.

Parameters:
- DIV, 6: master clocks per internal cycle; legal range 2..63.
- DEPTH, 4: FIFO entries; power of 2, range 2..16.
- BUSY_CYC, 32: internal cycles busy stays set after a data write is replayed; range 1..255.

Ports:
- rst  in  1  asynchronous, active-high reset
- clk  in  1  master clock
- cpu_wr  in  1  single-clk write strobe
- cpu_addr  in  2  bit1 = part (0/1), bit0 = 0 address write / 1 data write
- cpu_din  in  8  write data
- cpu_dout  out  8  status: bit7 busy, bit6 overflow (see Optional Feature), bits5:0 = 0
- cen_int  out  1  internal clock enable, one clk high every DIV clks
- rst_int  out  1  internal reset
- int_wr  out  1  replayed write valid, held for one internal cycle
- int_part  out  1  part of replayed write
- int_a0  out  1  address(0)/data(1) of replayed write
- int_din  out  8  replayed data
- busy  out  1  same as cpu_dout[7]
- overflow  out  1  sticky FIFO overflow flag

Behaviour:
- Reset values: phase counter 0, cen_int 0, rst_int 1, int_wr/int_part/int_a0/int_din 0, busy 0, overflow 0, FIFO empty, busy counter 0.
- Phase counter:
  - Counts 0..DIV-1 and wraps.
  - cen_int is registered; it is high in the clk cycle following counter==DIV-1.
  - First cen_int pulse is DIV clk edges after rst falls; pulses repeat every DIV clks.
- Internal reset:
  - Two-stage shift register clocked on cen_int, forced to 1 by rst.
  - rst_int falls at the second cen_int edge after rst release (2*DIV clks).
- FIFO push:
  - On cpu_wr with rst_int==0, {part, a0, din} is pushed.
  - A push is accepted if the pre-edge count < DEPTH, or if a pop occurs on the same edge.
  - Otherwise the write is dropped and the overflow flag is set.
  - cpu_wr while rst_int==1 is ignored: not pushed, no overflow.
- FIFO pop:
  - On a clk edge with cen_int==1, rst_int==0 and FIFO non-empty, the head entry is popped into int_part/int_a0/int_din and int_wr is set to 1.
  - No bypass: a push to an empty FIFO is first visible at the next cen_int.
- int_wr deassertion:
  - On a cen_int edge with an empty FIFO, int_wr clears to 0.
  - int_part/int_a0/int_din hold their last values.
  - Back-to-back entries keep int_wr high continuously while the fields change at each cen_int.
- Busy counter:
  - Loaded with BUSY_CYC when a popped entry has a0==1.
  - Decrements by 1 on each later cen_int while nonzero; a reload on a new data pop overrides the decrement.
  - busy is registered: (FIFO non-empty) OR (counter != 0). It updates one clk after the causing push/pop.
- Counts and pointers wrap modulo DEPTH; occupancy is tracked with an extra count bit so full and empty are distinct.
- Reset mid-operation: rst asynchronously returns every register to its reset value and flushes the FIFO; pending writes are lost.

Optional Feature:
- Macro: JT12_WR_OVF_FLAG_EN.
- Defined:
  - overflow is sticky, set by a dropped push and cleared only by rst.
  - cpu_dout[6] = overflow.
- Undefined:
  - overflow and cpu_dout[6] are tied 0.
  - Dropped writes are still discarded silently.

Test Plan:
- Reset/clock: DIV=6; release rst at t0 -> cen_int pulses at clk edges 6, 12, 18…; rst_int falls at edge 12; all other outputs stay 0.
- Single write: after rst_int=0, cpu_wr with addr=2'b10, din=0x28 -> at next cen_int, int_wr=1, int_part=1, int_a0=0, int_din=0x28 for exactly 6 clks; busy=1 only while the FIFO holds the entry.
- Data busy: write addr=2'b01, din=0xF0 -> after replay, busy stays 1 for 32 cen_int pulses (192 clks), then 0; cpu_dout=0x80 during that window, then 0x00.
- Burst: 4 writes on consecutive clks (0x22, 0x0F, 0x2B, 0x80) -> replayed in order on 4 consecutive cen_int; int_wr continuously high for 24 clks, then 0.
- Overflow: 5 writes in one internal cycle with DEPTH=4 -> 5th dropped, only 4 replayed; with JT12_WR_OVF_FLAG_EN, overflow=1 and cpu_dout[6]=1 until rst; without it both stay 0.
- Mid-op reset: assert rst with 3 queued entries and busy counter at 10 -> next cycle FIFO empty, busy=0, int_wr=0, rst_int=1; no stale replay after release.
